// File: rtl/bcd_countdown_pkg.sv
// Shared definitions for the two-digit BCD countdown timer.
package bcd_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Replace any non-BCD digit value with the largest legal digit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down counter, chainable through borrow.
module bcd_down_digit
    import bcd_countdown_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    // Digit register: load has priority; a decrement from 0 wraps to 9.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_value;
        end else if (dec && borrow_in) begin
            digit <= (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
        end
    end

    // Borrow into the next digit when this one wraps.
    assign borrow_out = dec && borrow_in && (digit == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown.sv
// Two-digit BCD countdown timer with load/start/pause control and reload.
module bcd_countdown
    import bcd_countdown_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       start,
    input  logic       pause,
    input  logic       tick,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic       done_pulse
);

    state_t     state;
    state_t     state_next;
    logic [7:0] reload;
    logic [7:0] din_clamped;

    logic       digit_load;
    logic [7:0] digit_value;
    logic       dec_en;
    logic       reload_we;
    logic       busy_next;
    logic       done_next;
    logic       pulse_next;

    logic [3:0] units;
    logic [3:0] tens;
    logic       units_borrow;
    logic       underflow;

    assign din_clamped = {clamp_digit(din[7:4]), clamp_digit(din[3:0])};
    assign dout        = {tens, units};

    // A decrement happens only in RUN on a tick with no higher-priority input.
    assign dec_en = (state == RUN) && !load && !pause && !start && tick;

    bcd_down_digit u_units (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (digit_load),
        .load_value (digit_value[3:0]),
        .dec        (dec_en),
        .borrow_in  (1'b1),
        .digit      (units),
        .borrow_out (units_borrow)
    );

    bcd_down_digit u_tens (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (digit_load),
        .load_value (digit_value[7:4]),
        .dec        (dec_en),
        .borrow_in  (units_borrow),
        .digit      (tens),
        .borrow_out (underflow)
    );

    // State and registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= busy_next;
            done       <= done_next;
            done_pulse <= pulse_next;
        end
    end

    // Reload register, written only by load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reload <= '0;
        end else if (reload_we) begin
            reload <= din_clamped;
        end
    end

    // Next-state selection, priority load > pause > start > tick.
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!pause && start) begin
                        state_next = (dout != 8'h00) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (!start && tick) begin
                        // underflow is a guard only; RUN never holds 00
                        if (dout == 8'h01 || underflow) begin
                            state_next = DONE;
                        end
                    end
                end
                PAUSED: begin
                    if (!pause && start) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                    if (!pause && start) begin
                        state_next = (reload != 8'h00) ? RUN : DONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath controls and next values of the registered outputs.
    always_comb begin
        digit_load  = 1'b0;
        digit_value = din_clamped;
        reload_we   = 1'b0;
        pulse_next  = 1'b0;
        if (load) begin
            digit_load = 1'b1;
            reload_we  = 1'b1;
        end else if (!pause && start && state == DONE) begin
            digit_load  = 1'b1;
            digit_value = reload;
        end
        if (!load && state_next == DONE) begin
            pulse_next = (state == IDLE || state == RUN) ? (state_next != state)
                                                         : (state == DONE && !pause && start);
        end
        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed scoreboard bench for bcd_countdown.
module tb_bcd_countdown;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       load;
    logic [7:0] din;
    logic       start;
    logic       pause;
    logic       tick;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic       done_pulse;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [10:0] sb_q[$];

    bcd_countdown dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (load),
        .din        (din),
        .start      (start),
        .pause      (pause),
        .tick       (tick),
        .dout       (dout),
        .busy       (busy),
        .done       (done),
        .done_pulse (done_pulse)
    );

    always #5 clock = ~clock;

    // Reference decrement through integer arithmetic.
    function automatic logic [7:0] bcd_minus1(input logic [7:0] v);
        int n;
        n = int'(v[7:4]) * 10 + int'(v[3:0]) - 1;
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got dout=%h busy=%b done=%b pulse=%b, expected dout=%h busy=%b done=%b pulse=%b",
                   tag, obs[10:3], obs[2], obs[1], obs[0], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs, queue its expected outputs, compare after the edge.
    task automatic step(input string tag, input logic l, input logic [7:0] d, input logic s,
                        input logic p, input logic t, input logic [7:0] e_dout,
                        input logic e_busy, input logic e_done, input logic e_pulse);
        logic [10:0] exp;
        @(negedge clock);
        load = l; din = d; start = s; pause = p; tick = t;
        sb_q.push_back({e_dout, e_busy, e_done, e_pulse});
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = sb_q.pop_front();
            check(tag, {dout, busy, done, done_pulse}, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_v;
        reset_n = 1'b0; load = 1'b0; din = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;
        #12;
        check("reset", {dout, busy, done, done_pulse}, 11'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Count 12 down to 00.
        step("load12", 1, 8'h12, 0, 0, 0, 8'h12, 0, 0, 0);
        step("start12", 0, 8'h00, 1, 0, 0, 8'h12, 1, 0, 0);
        exp_v = 8'h12;
        for (int i = 0; i < 12; i++) begin
            exp_v = bcd_minus1(exp_v);
            step("tick12", 0, 8'h00, 0, 0, 1, exp_v, exp_v != 8'h00, exp_v == 8'h00, exp_v == 8'h00);
        end
        step("done_hold", 0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 0);

        // Clamp and BCD borrow.
        step("loadFA", 1, 8'hFA, 0, 0, 0, 8'h99, 0, 0, 0);
        step("idle_tick", 0, 8'h00, 0, 0, 1, 8'h99, 0, 0, 0);
        step("start99", 0, 8'h00, 1, 0, 0, 8'h99, 1, 0, 0);
        exp_v = 8'h99;
        for (int i = 0; i < 10; i++) begin
            exp_v = bcd_minus1(exp_v);
            step("tick99", 0, 8'h00, 0, 0, 1, exp_v, 1, 0, 0);
        end
        step("loadA3", 1, 8'hA3, 0, 0, 0, 8'h93, 0, 0, 0);
        step("load3C", 1, 8'h3C, 0, 0, 0, 8'h39, 0, 0, 0);

        // Pause and resume.
        step("load05", 1, 8'h05, 0, 0, 0, 8'h05, 0, 0, 0);
        step("start05", 0, 8'h00, 1, 0, 0, 8'h05, 1, 0, 0);
        step("tick04", 0, 8'h00, 0, 0, 1, 8'h04, 1, 0, 0);
        step("tick03", 0, 8'h00, 0, 0, 1, 8'h03, 1, 0, 0);
        step("pause", 0, 8'h00, 0, 1, 1, 8'h03, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step("paused_tick", 0, 8'h00, 0, 0, 1, 8'h03, 0, 0, 0);
        step("pause_start", 0, 8'h00, 1, 1, 0, 8'h03, 0, 0, 0);
        step("resume", 0, 8'h00, 1, 0, 0, 8'h03, 1, 0, 0);
        step("tick02", 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0);
        step("tick01", 0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0);
        step("tick00", 0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 1);

        // Zero load goes straight to DONE; restart with zero reload re-pulses.
        step("load00", 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
        step("start00", 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1);
        step("done00", 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
        step("restart00", 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1);
        step("done00b", 0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 0);

        // Reload from DONE, then load wins over pause and start.
        step("load20", 1, 8'h20, 0, 0, 0, 8'h20, 0, 0, 0);
        step("start20", 0, 8'h00, 1, 0, 0, 8'h20, 1, 0, 0);
        exp_v = 8'h20;
        for (int i = 0; i < 20; i++) begin
            exp_v = bcd_minus1(exp_v);
            step("tick20", 0, 8'h00, 0, 0, 1, exp_v, exp_v != 8'h00, exp_v == 8'h00, exp_v == 8'h00);
        end
        step("reload20", 0, 8'h00, 1, 0, 0, 8'h20, 1, 0, 0);
        step("load_prio", 1, 8'h31, 1, 1, 1, 8'h31, 0, 0, 0);

        // Asynchronous reset mid-RUN.
        step("load09", 1, 8'h09, 0, 0, 0, 8'h09, 0, 0, 0);
        step("start09", 0, 8'h00, 1, 0, 0, 8'h09, 1, 0, 0);
        step("tick08", 0, 8'h00, 0, 0, 1, 8'h08, 1, 0, 0);
        step("tick07", 0, 8'h00, 0, 0, 1, 8'h07, 1, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {dout, busy, done, done_pulse}, 11'h0);
        @(posedge clock);
        #1;
        check("reset_hold", {dout, busy, done, done_pulse}, 11'h0);
        @(negedge clock);
        reset_n = 1'b1;
        tick = 1'b0;
        step("post_reset", 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_countdown.md
BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 Parameter: none; width fixed at two BCD digits (00-99).
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 load  input  1  load din into counter and reload register.
REQ-005 din  input  8  load value; [7:4] tens digit, [3:0] units digit.
REQ-006 start  input  1  begin or resume countdown.
REQ-007 pause  input  1  suspend countdown.
REQ-008 tick  input  1  count-enable strobe; one decrement per sampled high cycle.
REQ-009 dout  output  8  current count, registered; [7:4] tens, [3:0] units.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  high while in DONE.
REQ-012 done_pulse  output  1  single-cycle strobe on entry to DONE.

Function
REQ-013 States: IDLE, RUN, PAUSED, DONE; all outputs registered.
REQ-014 Input priority per cycle: load > pause > start > tick.
REQ-015 load in any state: dout <= clamped din, reload <= clamped din, state -> IDLE, done_pulse low.
REQ-016 Clamp: a din digit above 9 is replaced by 9 (e.g. din=8'hA3 loads 8'h93).
REQ-017 IDLE + start: dout!=00 -> RUN; dout==00 -> DONE with done_pulse next cycle.
REQ-018 RUN + tick: decrement by one in BCD; units 0 -> 9 with tens decremented; dout never holds a non-BCD digit.
REQ-019 RUN + tick at dout==01: dout -> 00, state -> DONE, and done_pulse high for exactly one cycle, all on the same edge.
REQ-020 RUN + pause: -> PAUSED on the same edge; no decrement that cycle, even if tick is high.
REQ-021 PAUSED: dout holds; tick ignored; start -> RUN; pause and start together stay in PAUSED.
REQ-022 DONE: dout holds 00; tick ignored; start -> dout <= reload, state -> RUN if reload!=00, else it re-enters DONE with a new done_pulse.
REQ-023 tick in IDLE: ignored.
REQ-024 Latency: all state and dout updates take effect one clock after the inputs are sampled.
REQ-025 busy = (state==RUN); done = (state==DONE); both registered with the state.

Reset
REQ-026 When reset_n is low: dout=8'h00, reload=8'h00, state=IDLE, busy=0, done=0, done_pulse=0, immediately and independently of clock.
REQ-027 Reset mid-countdown aborts the countdown with no done_pulse.
REQ-028 After reset_n deasserts, the first active edge behaves as in IDLE.

Structure
REQ-029 Shared package holds the state enumeration (2-bit), BCD_MAX=4'd9, and BCD_ZERO=4'd0.
REQ-030 One sub-module, bcd_down_digit: a 4-bit digit register with load, dec, borrow_in and borrow_out (asserted when the digit is 0 and dec is active).
REQ-031 bcd_down_digit is instantiated twice (units, tens), chained through borrow; the FSM and reload register live in the top module.

Verification
REQ-032 Reset, load din=8'h12, start, then 12 ticks: dout steps 12,11,10,09,...,01,00; done_pulse high only on the cycle dout becomes 00; done=1; busy=0.
REQ-033 Load 8'hFA then start: dout=8'h99 after load; first tick gives 98; the 10th tick gives 89.
REQ-034 Load 8'h05, start, 2 ticks (dout=03), pause with tick high: dout stays 03 over 5 ticks; start resumes; 3 ticks -> 00 and DONE.
REQ-035 Load 8'h00 then start: DONE next cycle with one done_pulse; dout=00.
REQ-036 Load 8'h20, run to DONE, then start: dout=20 and busy=1; load, pause and start asserted together -> load wins, state IDLE.
REQ-037 Assert reset_n low mid-RUN at dout=07, asynchronously between edges: all outputs zero immediately, no done_pulse.
